// File: rtl/fifo_pkg.sv
// Shared types and helpers for the parametrised synchronous FIFO.
// Address width helper and packed status bundle.
package fifo_pkg;

    function automatic int fifo_addr_w(input int depth);
        return (depth <= 2) ? 1 : $clog2(depth);
    endfunction

    typedef struct packed {
        logic not_full;
        logic not_empty;
        logic almost_full;
        logic almost_empty;
    } fifo_status_t;

endpackage

// File: rtl/sync_fifo_mem.sv
// DEPTH x WIDTH register array: one write port, one async read port,
// asynchronous clear of every entry.
module sync_fifo_mem
    import fifo_pkg::*;
#(
    parameter int WIDTH  = 49,
    parameter int DEPTH  = 4,
    parameter int ADDR_W = fifo_addr_w(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [ADDR_W-1:0] w_addr,
    input  logic [WIDTH-1:0]  w_data,
    input  logic [ADDR_W-1:0] r_addr,
    output logic [WIDTH-1:0]  r_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            mem[w_addr] <= w_data;
        end
    end

    assign r_data = mem[r_addr];

endmodule

// File: rtl/sync_fifo_param.sv
// Parametrised single-clock FWFT FIFO with occupancy and threshold flags.
// Define FIFO_ERR_FLAG_EN to build sticky overflow/underflow flags.
module sync_fifo_param
    import fifo_pkg::*;
#(
    parameter int WIDTH     = 49,
    parameter int DEPTH     = 4,
    parameter int AF_THRESH = 3,
    parameter int AE_THRESH = 1,
    localparam int ADDR_W   = fifo_addr_w(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              wr_en,
    input  logic [WIDTH-1:0]  w_data,
    input  logic              rd_en,
    output logic [WIDTH-1:0]  r_data,
    output logic              not_full,
    output logic              not_empty,
    output logic [ADDR_W:0]   count,
    output logic              almost_full,
    output logic              almost_empty,
    output logic              overflow,
    output logic              underflow
);

    if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
        $fatal(1, "sync_fifo_param: DEPTH must be a power of 2 >= 2");
    end
    if ((AF_THRESH < 1) || (AF_THRESH > DEPTH)) begin : g_bad_af
        $fatal(1, "sync_fifo_param: AF_THRESH out of range");
    end
    if ((AE_THRESH < 0) || (AE_THRESH > DEPTH - 1)) begin : g_bad_ae
        $fatal(1, "sync_fifo_param: AE_THRESH out of range");
    end

    localparam logic [ADDR_W:0] AF_LVL = AF_THRESH[ADDR_W:0];
    localparam logic [ADDR_W:0] AE_LVL = AE_THRESH[ADDR_W:0];

    logic [ADDR_W:0] w_ptr;
    logic [ADDR_W:0] r_ptr;
    logic            full;
    logic            empty;
    logic            wr_ok;
    logic            rd_ok;
    fifo_status_t    status;

    assign empty = (w_ptr == r_ptr);
    assign full  = (w_ptr[ADDR_W] != r_ptr[ADDR_W]) &&
                   (w_ptr[ADDR_W-1:0] == r_ptr[ADDR_W-1:0]);
    assign wr_ok = wr_en && !full;
    assign rd_ok = rd_en && !empty;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            w_ptr <= '0;
            r_ptr <= '0;
        end else if (flush) begin
            w_ptr <= '0;
            r_ptr <= '0;
        end else begin
            if (wr_ok) w_ptr <= w_ptr + 1'b1;
            if (rd_ok) r_ptr <= r_ptr + 1'b1;
        end
    end

    // Flush wins over a same-cycle write, so the array is left untouched.
    sync_fifo_mem #(
        .WIDTH  (WIDTH),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_mem (
        .clk    (clk),
        .rst_n  (rst_n),
        .we     (wr_ok && !flush),
        .w_addr (w_ptr[ADDR_W-1:0]),
        .w_data (w_data),
        .r_addr (r_ptr[ADDR_W-1:0]),
        .r_data (r_data)
    );

    assign count = w_ptr - r_ptr;

    assign status = '{
        not_full:     !full,
        not_empty:    !empty,
        almost_full:  (count >= AF_LVL),
        almost_empty: (count <= AE_LVL)
    };

    assign not_full     = status.not_full;
    assign not_empty    = status.not_empty;
    assign almost_full  = status.almost_full;
    assign almost_empty = status.almost_empty;

`ifdef FIFO_ERR_FLAG_EN
    logic ovf_q;
    logic udf_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q <= 1'b0;
            udf_q <= 1'b0;
        end else if (flush) begin
            ovf_q <= 1'b0;
            udf_q <= 1'b0;
        end else begin
            if (wr_en && full) begin
                ovf_q <= 1'b1;
                $error("sync_fifo_param: write while full");
            end
            if (rd_en && empty) begin
                udf_q <= 1'b1;
                $error("sync_fifo_param: read while empty");
            end
        end
    end

    assign overflow  = ovf_q;
    assign underflow = udf_q;
`else
    assign overflow  = 1'b0;
    assign underflow = 1'b0;
`endif

endmodule

// File: tb/tb_sync_fifo_param.sv
// Directed scoreboard bench for sync_fifo_param (DEPTH=4, WIDTH=49).
module tb_sync_fifo_param;

`ifdef FIFO_ERR_FLAG_EN
    localparam logic ERR = 1'b1;
`else
    localparam logic ERR = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        wr_en = 1'b0;
    logic [48:0] w_data = '0;
    logic        rd_en = 1'b0;
    logic [48:0] r_data;
    logic        not_full;
    logic        not_empty;
    logic [2:0]  count;
    logic        almost_full;
    logic        almost_empty;
    logic        overflow;
    logic        underflow;

    int n_chk = 0;
    int n_pass = 0;
    int mcount = 0;
    logic [48:0] exp_q [$];

    always #5 clk = ~clk;

    sync_fifo_param #(
        .WIDTH(49), .DEPTH(4), .AF_THRESH(3), .AE_THRESH(1)
    ) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .wr_en(wr_en), .w_data(w_data), .rd_en(rd_en),
        .r_data(r_data), .not_full(not_full), .not_empty(not_empty),
        .count(count), .almost_full(almost_full),
        .almost_empty(almost_empty), .overflow(overflow),
        .underflow(underflow)
    );

    function automatic void chk(input string name,
                                input logic [63:0] act,
                                input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endfunction

    // Monitor: every accepted pop is compared against the scoreboard head.
    always @(negedge clk) begin
        if (rst_n && rd_en && not_empty && !flush) begin
            if (exp_q.size() == 0) begin
                chk("pop_unexpected", 64'd1, 64'd0);
            end else begin
                chk("r_data", 64'(r_data), 64'(exp_q.pop_front()));
            end
        end
    end

    task automatic step(input logic w, input logic [48:0] d, input logic r);
        logic wacc;
        logic racc;
        wacc = w && (mcount < 4);
        racc = r && (mcount > 0);
        wr_en = w;
        w_data = d;
        rd_en = r;
        if (wacc) exp_q.push_back(d);
        @(posedge clk);
        #1;
        mcount = mcount + int'(wacc) - int'(racc);
        wr_en = 1'b0;
        rd_en = 1'b0;
    endtask

    task automatic chk_flags(input string tag, input int c);
        chk({tag, "_count"}, 64'(count), 64'(c));
        chk({tag, "_af"}, 64'(almost_full), 64'(c >= 3));
        chk({tag, "_ae"}, 64'(almost_empty), 64'(c <= 1));
        chk({tag, "_nf"}, 64'(not_full), 64'(c < 4));
        chk({tag, "_ne"}, 64'(not_empty), 64'(c > 0));
    endtask

    initial begin
        // Reset
        #12;
        chk_flags("rst", 0);
        chk("rst_rdata", 64'(r_data), 64'd0);
        chk("rst_ovf", 64'(overflow), 64'd0);
        chk("rst_udf", 64'(underflow), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Fill
        for (int i = 1; i <= 4; i++) begin
            step(1'b1, 49'(i), 1'b0);
            chk_flags("fill", i);
        end
        step(1'b1, 49'h5, 1'b0);
        chk_flags("ovf", 4);
        chk("ovf_flag", 64'(overflow), 64'(ERR));

        // Drain
        for (int i = 3; i >= 0; i--) begin
            step(1'b0, '0, 1'b1);
            chk_flags("drain", i);
        end
        step(1'b0, '0, 1'b1);
        chk_flags("udf", 0);
        chk("udf_flag", 64'(underflow), 64'(ERR));

        // Wrap
        for (int k = 0; k < 10; k++) begin
            step(1'b1, 49'h100 + 49'(2 * k), 1'b0);
            step(1'b1, 49'h101 + 49'(2 * k), 1'b0);
            chk("wrap_count2", 64'(count), 64'd2);
            step(1'b0, '0, 1'b1);
            step(1'b0, '0, 1'b1);
            chk("wrap_count0", 64'(count), 64'd0);
        end

        // Simultaneous while full
        for (int i = 0; i < 4; i++) step(1'b1, 49'hA0 + 49'(i), 1'b0);
        chk_flags("sim_full", 4);
        step(1'b1, 49'hBB, 1'b1);
        chk_flags("sim_full_rw", 3);
        chk("sim_full_head", 64'(r_data), 64'hA1);
        for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b1);
        chk_flags("sim_drained", 0);

        // Simultaneous while empty
        step(1'b1, 49'h1_2345_6789_ABCD, 1'b1);
        chk_flags("sim_empty_rw", 1);
        chk("sim_empty_rdata", 64'(r_data), 64'h1_2345_6789_ABCD);
        step(1'b0, '0, 1'b1);
        chk_flags("sim_empty_pop", 0);

        // Flush with a concurrent write
        for (int i = 0; i < 3; i++) step(1'b1, 49'hF0 + 49'(i), 1'b0);
        chk_flags("pre_flush", 3);
        flush = 1'b1;
        wr_en = 1'b1;
        w_data = 49'hDEAD;
        @(posedge clk);
        #1;
        flush = 1'b0;
        wr_en = 1'b0;
        exp_q.delete();
        mcount = 0;
        chk_flags("flush", 0);
        chk("flush_ovf", 64'(overflow), 64'd0);
        chk("flush_udf", 64'(underflow), 64'd0);

        // Post-flush traffic restarts from address 0
        step(1'b1, 49'h77, 1'b0);
        chk("post_flush_rdata", 64'(r_data), 64'h77);
        step(1'b0, '0, 1'b1);
        chk_flags("post_flush", 0);

        chk("scoreboard_left", 64'(exp_q.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
